alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 start  input  1  operation request, sampled only in IDLE.
REQ-005 op  input  1  0 = Booth multiply, 1 = non-restoring divide; captured with start.
REQ-006 q0, q_m1  input  1 each  Booth pair from Q register LSB and the extra Q(-1) flop.
REQ-007 a8  input  1  sign bit (MSB) of the 9-bit A register.
REQ-008 clr_a, load_q, load_m  output  1 each  clear A / load Q / load M from operand buses.
REQ-009 load_a, add, sub  output  1 each  A <= A+M (load_a&add) or A <= A-M (load_a&sub).
REQ-010 rshift_a, rshift_q, lshift_a, lshift_q  output  1 each  shift strobes for A and Q.
REQ-011 a7_mem  output  1  arithmetic right-shift select for A (bit 7 receives bit 8).
REQ-012 set_q0, q0_val  output  1 each  write Q bit 0 with q0_val.
REQ-013 count  output  3  iteration index 0..7; busy  output 1; done  output 1.

Function
REQ-014 States: IDLE, INIT, M_TEST, M_ADD, M_SUB, M_SHIFT, D_SHIFT, D_ADDSUB, D_SETQ, D_CORR, DONE.
REQ-015 Outputs SHALL be decoded from the state register (plus a8/latched op); every strobe not listed for a state is 0.
REQ-016 IDLE: busy=0; start=1 -> INIT and op latched; start=0 -> stay.
REQ-017 start while not IDLE SHALL be ignored; op changes while busy SHALL have no effect.
REQ-018 INIT (1 cycle): clr_a=load_q=load_m=1; count <= 0; next M_TEST (op=0) or D_SHIFT (op=1).
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 M_TEST: no strobes; {q0,q_m1}=10 -> M_SUB, 01 -> M_ADD, 00/11 -> M_SHIFT.
REQ-021 M_ADD: load_a=add=1; M_SUB: load_a=sub=1; both -> M_SHIFT.
REQ-022 M_SHIFT: rshift_a=rshift_q=a7_mem=1; count==7 -> DONE, else count <= count+1 and -> M_TEST.
REQ-023 D_SHIFT: lshift_a=lshift_q=1 -> D_ADDSUB.
REQ-024 D_ADDSUB: load_a=1 with add=1 if a8=1 else sub=1 -> D_SETQ.
REQ-025 D_SETQ: set_q0=1, q0_val=~a8; count==7 -> D_CORR, else count <= count+1 and -> D_SHIFT.
REQ-026 D_CORR: if a8=1 then load_a=add=1 (remainder restore), else no strobes; -> DONE.
REQ-027 DONE: done=1 for exactly one cycle, busy=1; -> IDLE; count holds 7 until next INIT.
REQ-028 add and sub SHALL never be 1 in the same cycle; lshift_* and rshift_* SHALL never be 1 together.
REQ-029 Multiply latency: start sampled at edge N -> done high in cycle N+18+k, k = number of M_ADD/M_SUB visits.
REQ-030 Divide latency: start sampled at edge N -> done high in cycle N+27, independent of data.

Reset
REQ-031 reset=1 SHALL force IDLE, count=0 and all outputs 0 on the next edge, from any state, overriding start.
REQ-032 Reset mid-operation SHALL abort without a done pulse; a start after reset release SHALL begin a fresh INIT.

Verification
REQ-033 Reset then start=1,op=0, hold {q0,q_m1}=00 -> INIT one cycle, 8x(M_TEST,M_SHIFT), done pulse in cycle N+18, count=7.
REQ-034 op=0, {q0,q_m1}=10 at every M_TEST -> 8 sub pulses, 8 shift pulses with a7_mem=1, done at N+26.
REQ-035 op=1, a8=0 throughout -> 8 sub pulses, 8 set_q0 with q0_val=1, no add in D_CORR, done at N+27.
REQ-036 op=1, a8=1 throughout -> 8 add pulses in D_ADDSUB, q0_val=0, D_CORR add pulse, done at N+27.
REQ-037 start pulsed during M_SHIFT -> ignored, single done; assert reset in D_ADDSUB -> IDLE next edge, no done.
REQ-038 Every cycle of all scenarios: no add&sub, no lshift&rshift overlap, busy=0 only in IDLE.

Source files
------------

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_if
// Description : Handshake and datapath-control bundle between the Booth /
//               non-restoring sequencer and its 9-bit A / 8-bit Q datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
    logic       start;
    logic       op;
    logic       q0;
    logic       q_m1;
    logic       a8;
    logic       clr_a;
    logic       load_q;
    logic       load_m;
    logic       load_a;
    logic       add;
    logic       sub;
    logic       rshift_a;
    logic       rshift_q;
    logic       lshift_a;
    logic       lshift_q;
    logic       a7_mem;
    logic       set_q0;
    logic       q0_val;
    logic [2:0] count;
    logic       busy;
    logic       done;

    modport master (
        input  start, op, q0, q_m1, a8,
        output clr_a, load_q, load_m, load_a, add, sub,
               rshift_a, rshift_q, lshift_a, lshift_q, a7_mem,
               set_q0, q0_val, count, busy, done
    );

    modport slave (
        output start, op, q0, q_m1, a8,
        input  clr_a, load_q, load_m, load_a, add, sub,
               rshift_a, rshift_q, lshift_a, lshift_q, a7_mem,
               set_q0, q0_val, count, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Control FSM for 8-bit Booth multiply / non-restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer (
    input  wire logic       clk,
    input  wire logic       reset,
    alu_sequencer_if.master bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INIT     = 4'd1;
    localparam logic [3:0] S_M_TEST   = 4'd2;
    localparam logic [3:0] S_M_ADD    = 4'd3;
    localparam logic [3:0] S_M_SUB    = 4'd4;
    localparam logic [3:0] S_M_SHIFT  = 4'd5;
    localparam logic [3:0] S_D_SHIFT  = 4'd6;
    localparam logic [3:0] S_D_ADDSUB = 4'd7;
    localparam logic [3:0] S_D_SETQ   = 4'd8;
    localparam logic [3:0] S_D_CORR   = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;

    localparam logic [2:0] C_LAST     = 3'd7;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_op;
    logic [2:0] r_count;

    // State-only strobes are registered from the next state; the a8-dependent
    // terms are combined below because a8 is only valid in the current cycle.
    logic r_init, r_m_add, r_m_sub, r_m_shift, r_d_shift;
    logic r_d_addsub, r_d_setq, r_d_corr, r_done, r_busy;

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:     w_next = bus.start ? S_INIT : S_IDLE;
            S_INIT:     w_next = r_op ? S_D_SHIFT : S_M_TEST;
            S_M_TEST: begin
                case ({bus.q0, bus.q_m1})
                    2'b10:   w_next = S_M_SUB;
                    2'b01:   w_next = S_M_ADD;
                    default: w_next = S_M_SHIFT;
                endcase
            end
            S_M_ADD:    w_next = S_M_SHIFT;
            S_M_SUB:    w_next = S_M_SHIFT;
            S_M_SHIFT:  w_next = (r_count == C_LAST) ? S_DONE : S_M_TEST;
            S_D_SHIFT:  w_next = S_D_ADDSUB;
            S_D_ADDSUB: w_next = S_D_SETQ;
            S_D_SETQ:   w_next = (r_count == C_LAST) ? S_D_CORR : S_D_SHIFT;
            S_D_CORR:   w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= 1'b0;
            r_count    <= 3'd0;
            r_init     <= 1'b0;
            r_m_add    <= 1'b0;
            r_m_sub    <= 1'b0;
            r_m_shift  <= 1'b0;
            r_d_shift  <= 1'b0;
            r_d_addsub <= 1'b0;
            r_d_setq   <= 1'b0;
            r_d_corr   <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_op <= bus.op;
            end
            if (r_state == S_INIT) begin
                r_count <= 3'd0;
            end else if ((r_state == S_M_SHIFT || r_state == S_D_SETQ) &&
                         r_count != C_LAST) begin
                r_count <= r_count + 3'd1;
            end
            r_init     <= (w_next == S_INIT);
            r_m_add    <= (w_next == S_M_ADD);
            r_m_sub    <= (w_next == S_M_SUB);
            r_m_shift  <= (w_next == S_M_SHIFT);
            r_d_shift  <= (w_next == S_D_SHIFT);
            r_d_addsub <= (w_next == S_D_ADDSUB);
            r_d_setq   <= (w_next == S_D_SETQ);
            r_d_corr   <= (w_next == S_D_CORR);
            r_done     <= (w_next == S_DONE);
            r_busy     <= (w_next != S_IDLE);
        end
    end

    assign bus.clr_a    = r_init;
    assign bus.load_q   = r_init;
    assign bus.load_m   = r_init;
    assign bus.load_a   = r_m_add | r_m_sub | r_d_addsub | (r_d_corr & bus.a8);
    assign bus.add      = r_m_add | ((r_d_addsub | r_d_corr) & bus.a8);
    assign bus.sub      = r_m_sub | (r_d_addsub & ~bus.a8);
    assign bus.rshift_a = r_m_shift;
    assign bus.rshift_q = r_m_shift;
    assign bus.a7_mem   = r_m_shift;
    assign bus.lshift_a = r_d_shift;
    assign bus.lshift_q = r_d_shift;
    assign bus.set_q0   = r_d_setq;
    assign bus.q0_val   = r_d_setq & ~bus.a8;
    assign bus.count    = r_count;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire
